// File: rtl/robo_ambiente.sv
`default_nettype none
// ============================================================================
// robo_ambiente : grid-world plant for the Robo controller (walls, debris, pose)
// Revision      : 1.0
// ============================================================================
module robo_ambiente #(
  parameter int         LINHAS         = 10,
  parameter int         COLUNAS        = 20,
  parameter int         LINHA_INICIAL  = 10,
  parameter int         COLUNA_INICIAL = 1,
  parameter logic [1:0] ORIENT_INICIAL = 2'b00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mapa_we,
  input  logic [3:0]         mapa_linha,
  input  logic [COLUNAS-1:0] mapa_dado,
  input  logic               entulho_we,
  input  logic [7:0]         entulho_end,
  input  logic [1:0]         entulho_peso,
  input  logic               start,
  input  logic               avancar,
  input  logic               girar,
  input  logic               remover,
  output logic               head,
  output logic               left,
  output logic               under,
  output logic               barrier,
  output logic [3:0]         linha,
  output logic [4:0]         coluna,
  output logic [1:0]         orientacao,
  output logic [7:0]         movimentos,
  output logic               colisao,
  output logic               ativo
);

  localparam int NCEL = LINHAS * COLUNAS;
  localparam int RW   = $clog2(LINHAS);
  localparam int CW   = $clog2(COLUNAS);
  localparam int AW   = $clog2(NCEL);

  localparam logic [1:0] OR_N = 2'b00;
  localparam logic [1:0] OR_S = 2'b01;
  localparam logic [1:0] OR_L = 2'b10;
  localparam logic [1:0] OR_O = 2'b11;

  typedef enum logic [1:0] {
    CARGA = 2'd0,
    ATIVO = 2'd1,
    FALHA = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [3:0]         linha_q, linha_d;
  logic [4:0]         coluna_q, coluna_d;
  logic [1:0]         ori_q, ori_d, ori_rot;
  logic [7:0]         mov_q, mov_d;
  logic               colisao_q, colisao_d;
  logic [COLUNAS-1:0] parede_q [LINHAS];
  logic [1:0]         entulho_q [NCEL];

  int                 dl_f, dc_f, dl_e, dc_e;
  int                 fl, fc, el, ec;
  logic               f_dentro, e_dentro;
  logic [RW-1:0]      f_r, e_r, mapa_r;
  logic [CW-1:0]      f_b, e_b;
  logic [AW-1:0]      f_a;
  logic               multi, mapa_en, ent_en, rem_en;

  // Neighbour cells; anything off the grid is treated as a wall.
  always_comb begin
    dl_f = 0; dc_f = 0; dl_e = 0; dc_e = 0;
    unique case (ori_q)
      OR_N:    begin dl_f = -1; dc_e = -1; ori_rot = OR_O; end
      OR_S:    begin dl_f =  1; dc_e =  1; ori_rot = OR_L; end
      OR_L:    begin dc_f =  1; dl_e = -1; ori_rot = OR_N; end
      default: begin dc_f = -1; dl_e =  1; ori_rot = OR_S; end
    endcase
    fl = int'(linha_q) + dl_f;
    fc = int'(coluna_q) + dc_f;
    el = int'(linha_q) + dl_e;
    ec = int'(coluna_q) + dc_e;
    f_dentro = (fl >= 1) && (fl <= LINHAS) && (fc >= 1) && (fc <= COLUNAS);
    e_dentro = (el >= 1) && (el <= LINHAS) && (ec >= 1) && (ec <= COLUNAS);
    f_r = '0; f_b = '0; f_a = '0; e_r = '0; e_b = '0;
    if (f_dentro) begin
      f_r = RW'(fl - 1);
      f_b = CW'(COLUNAS - fc);
      f_a = AW'(COLUNAS * (fl - 1) + fc - 1);
    end
    if (e_dentro) begin
      e_r = RW'(el - 1);
      e_b = CW'(COLUNAS - ec);
    end
  end

  assign head    = !f_dentro || parede_q[f_r][f_b];
  assign barrier = !head && (entulho_q[f_a] != 2'd0);
  assign left    = !e_dentro || parede_q[e_r][e_b];
  assign under   = (int'(linha_q) == LINHA_INICIAL) && (int'(coluna_q) == COLUNA_INICIAL);

  always_comb begin
    estado_d  = estado_q;
    linha_d   = linha_q;
    coluna_d  = coluna_q;
    ori_d     = ori_q;
    mov_d     = mov_q;
    colisao_d = colisao_q;
    mapa_en   = 1'b0;
    ent_en    = 1'b0;
    rem_en    = 1'b0;
    mapa_r    = RW'(int'(mapa_linha) - 1);
    multi     = (avancar && girar) || (avancar && remover) || (girar && remover);
    unique case (estado_q)
      CARGA: begin
        mapa_en = mapa_we && (int'(mapa_linha) >= 1) && (int'(mapa_linha) <= LINHAS);
        ent_en  = entulho_we && (int'(entulho_end) < NCEL);
        if (start) estado_d = ATIVO;
      end
      ATIVO: begin
        if (multi || (avancar && (head || barrier))) begin
          colisao_d = 1'b1;
          estado_d  = FALHA;
        end else if (avancar || girar || remover) begin
          mov_d = (mov_q == 8'hFF) ? mov_q : mov_q + 8'd1;
          if (avancar) begin
            linha_d  = 4'(fl);
            coluna_d = 5'(fc);
          end
          if (girar) ori_d = ori_rot;
          rem_en = remover && barrier;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= CARGA;
      linha_q   <= 4'(LINHA_INICIAL);
      coluna_q  <= 5'(COLUNA_INICIAL);
      ori_q     <= ORIENT_INICIAL;
      mov_q     <= '0;
      colisao_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      linha_q   <= linha_d;
      coluna_q  <= coluna_d;
      ori_q     <= ori_d;
      mov_q     <= mov_d;
      colisao_q <= colisao_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parede_q  <= '{default: '0};
      entulho_q <= '{default: '0};
    end else begin
      if (mapa_en) parede_q[mapa_r] <= mapa_dado;
      if (ent_en)  entulho_q[entulho_end[AW-1:0]] <= entulho_peso;
      if (rem_en)  entulho_q[f_a] <= entulho_q[f_a] - 2'd1;
    end
  end

  assign linha      = linha_q;
  assign coluna     = coluna_q;
  assign orientacao = ori_q;
  assign movimentos = mov_q;
  assign colisao    = colisao_q;
  assign ativo      = (estado_q == ATIVO);

endmodule
`default_nettype wire
